rr_index_arbiter: RTL
=====================

Name: rr_index_arbiter

Overview:
- Round-robin arbiter over 32 request lines.
- Produces a registered 5-bit winner index A with a valid/ready handshake.
- Sits directly upstream of the 5-to-32 line decoder, which consumes A and turns it back into a one-hot select/enable.
- Guarantees A is held stable while presented, so the downstream decoded lines never glitch between grants.

Parameters:
- NREQ, 32, number of request lines; fixed at 32.
- AW, 5, index width; fixed at 5, so that 2^AW = NREQ.

Ports:
- clk  input  1  rising-edge clock, the only clock.
- rst_n  input  1  asynchronous active-low reset.
- req  input  32  request vector; bit i requests index i; may change any cycle.
- A  output  5  granted index, registered; feeds the decoder's A input.
- valid  output  1  A holds a live grant.
- ready  input  1  consumer accepts A this cycle.
- ptr  output  5  current round-robin start position, for debug/verification.

Behaviour:
- Reset (async assert, sync release by system):
  - A=0, valid=0, ptr=0.
  - State=IDLE.
- Search function:
  - Winner = first set bit of req scanning ptr, ptr+1, …, 31, 0, …, ptr-1 (mod 32).
  - Pure combinational; no priority beyond rotation order.
- States:
  - IDLE: valid=0. If req!=0 at an edge: A<=winner, valid<=1, go to GRANT. Else remain.
  - GRANT: valid=1; A, valid and ptr held stable until handshake (valid&ready at an edge).
- Handshake edge:
  - ptr<=A+1, 5-bit wrap, so 31->0.
  - In the same edge, rerun the search with start A+1 on current req, with bit A excluded.
  - If a winner exists: A<=winner, valid stays 1 (back-to-back, no bubble).
  - Else: valid<=0, A holds its old value, go to IDLE.
  - Excluding bit A keeps a lone persistent requester from being regranted without a bubble.
  - That requester regains grant 1 cycle later via IDLE.
- Latency:
  - req becomes nonzero before edge k in IDLE -> valid=1 and A valid after edge k (1 cycle).
  - Handshake to next grant: 0 bubbles if another requester is pending.
  - Handshake to next grant: 1 bubble if only the just-served index requests.
- Grants are sticky:
  - Deasserting req[A] while in GRANT does not revoke or change A.
  - The consumer still receives it.
- ready while valid=0 is ignored. ptr changes only on a handshake.
- Fairness: any continuously asserted request is granted within 32 handshakes.
- Async reset mid-GRANT: immediate return to reset values; the pending grant is dropped.
- No X on A at any time after reset.

Test Plan:
- Reset, then req=0 for 5 cycles -> valid=0, A=0, ptr=0 throughout.
- req=32'h0000_0010 with ready=1 constantly -> valid rises 1 cycle later with A=4. Then ptr=5, valid=0 for 1 cycle, A=4 re-granted, repeating with a 1-bubble pattern.
- req=32'h8000_0003, ready=1 -> grant order 0,1,31,0,1,31 with no bubbles; ptr wraps 31->0 after the grant of 31.
- req=32'h0000_0100, ready=0 for 6 cycles, req dropped to 0 on cycle 2 -> A=8, valid=1 held all 6 cycles. Then ready=1 -> handshake, ptr=9, valid=0.
- req=all ones, ready=1 for 64 cycles -> A sequence 0,1,…,31,0,…,31, each index exactly twice, valid continuously 1 after the first grant.
- rst_n pulsed low mid-GRANT (A=17) -> A=0, valid=0, ptr=0 immediately, without waiting for clk. After release with req=bit17, A=17 is granted 1 cycle after the first edge.

Source files
------------

// File: rtl/rr_index_arbiter.sv
// Round-robin arbiter over NREQ request lines with a registered winner index
// and a valid/ready handshake. The index A is held stable while valid is high,
// so a downstream index-to-one-hot decoder never glitches between grants.
module rr_index_arbiter #(
  parameter int NREQ = 32,
  parameter int AW   = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req,
  output logic [AW-1:0]   A,
  output logic            valid,
  input  logic            ready,
  output logic [AW-1:0]   ptr
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   a_q, a_d;
  logic [AW-1:0]   ptr_q, ptr_d;

  logic            handshake;
  logic [NREQ-1:0] req_excl;
  logic [AW-1:0]   hs_start;
  logic [AW:0]     idle_res;
  logic [AW:0]     hs_res;

  // Returns {found, index} of the first set bit of vec scanning upward from
  // start and wrapping modulo NREQ.
  function automatic logic [AW:0] search(input logic [NREQ-1:0] vec,
                                         input logic [AW-1:0]   start);
    logic          found;
    logic [AW-1:0] idx;
    logic [AW-1:0] pos;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < NREQ; i++) begin
      pos = start + AW'(i);
      if (!found && vec[pos]) begin
        found = 1'b1;
        idx   = pos;
      end
    end
    return {found, idx};
  endfunction

  assign handshake = (state_q == GRANT) && ready;
  assign hs_start  = a_q + AW'(1);

  // The just-served index is masked out of the handshake search so a lone
  // persistent requester sees a one-cycle bubble before being regranted.
  assign req_excl  = req & ~(NREQ'(1) << a_q);

  // Both searches run every cycle; the FSM picks which result it uses.
  always_comb begin
    idle_res = search(req, ptr_q);
    hs_res   = search(req_excl, hs_start);
  end

  // Next-state and next-grant selection.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    state_d = state_q;
    a_d     = a_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      IDLE: begin
        if (idle_res[AW]) begin
          a_d     = idle_res[AW-1:0];
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (handshake) begin
          ptr_d = hs_start;
          if (hs_res[AW]) begin
            a_d = hs_res[AW-1:0];
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, grant index and rotation pointer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: non-blocking assignments so every register samples the
    // pre-edge values, independent of statement order.
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      ptr_q   <= ptr_d;
    end
  end

  assign A     = a_q;
  assign valid = (state_q == GRANT);
  assign ptr   = ptr_q;

endmodule
